// File: rtl/uart_byte_rx_if.sv
// Receive-side UART bundle: serial line and baud select in, byte and status strobes out.
// The master drives the line (host or transmitter model); the slave is the receiver.
interface uart_byte_rx_if;
  logic       rx;
  logic [2:0] set_baud;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  modport master (
    output rx,
    output set_baud,
    input  data_byte,
    input  rx_done,
    input  frame_err,
    input  uart_state
  );

  modport slave (
    input  rx,
    input  set_baud,
    output data_byte,
    output rx_done,
    output frame_err,
    output uart_state
  );
endinterface

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote per bit,
// false-start rejection and framing-error strobe.
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  uart_byte_rx_if.slave bus
);

  localparam int unsigned DIV_9600   = CLK_FREQ / (9600 * 16);
  localparam int unsigned DIV_19200  = CLK_FREQ / (19200 * 16);
  localparam int unsigned DIV_38400  = CLK_FREQ / (38400 * 16);
  localparam int unsigned DIV_57600  = CLK_FREQ / (57600 * 16);
  localparam int unsigned DIV_115200 = CLK_FREQ / (115200 * 16);
  localparam int unsigned DIV_W      = $clog2(DIV_9600 + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t state, state_nxt;

  logic             rx_s1, rx_s2, rx_d;
  logic             rx_fall;
  logic [2:0]       baud_q;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_max;
  logic [3:0]       tick_idx;
  logic [3:0]       idx_nxt;
  logic             tick;
  logic             hit6, hit7, hit8, hit9, hit15;
  logic [1:0]       samp;
  logic             vote;
  logic [7:0]       shreg;
  logic [2:0]       bit_cnt;
  logic             stop_ok;
  logic             done_nxt, ferr_nxt, load_byte;
  logic [7:0]       data_byte_q;
  logic             rx_done_q, frame_err_q, uart_state_q;

  function automatic logic [DIV_W-1:0] div_max_of(input logic [2:0] sel);
    case (sel)
      3'd0:    div_max_of = DIV_W'(DIV_9600 - 1);
      3'd1:    div_max_of = DIV_W'(DIV_19200 - 1);
      3'd2:    div_max_of = DIV_W'(DIV_38400 - 1);
      3'd3:    div_max_of = DIV_W'(DIV_57600 - 1);
      default: div_max_of = DIV_W'(DIV_115200 - 1);
    endcase
  endfunction

  // NOTE: sync flops reset to the idle-high line level so reset release never fakes a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;
  assign div_max = div_max_of(baud_q);

  // "Index k" events fire on the tick that advances tick_idx to k, so index 0 is start detect.
  assign tick    = (state != S_IDLE) && (div_cnt == div_max);
  assign idx_nxt = tick_idx + 4'd1;
  assign hit6    = tick && (idx_nxt == 4'd6);
  assign hit7    = tick && (idx_nxt == 4'd7);
  assign hit8    = tick && (idx_nxt == 4'd8);
  assign hit9    = tick && (idx_nxt == 4'd9);
  assign hit15   = tick && (idx_nxt == 4'd15);

  // Third sample is the live line value on the index-8 tick.
  assign vote = (samp[0] & samp[1]) | (samp[0] & rx_s2) | (samp[1] & rx_s2);

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, which rules out latches.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    ferr_nxt  = 1'b0;
    load_byte = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_fall) state_nxt = S_START;
      end
      S_START: begin
        if (hit8 && vote)  state_nxt = S_IDLE;
        else if (hit15)    state_nxt = S_DATA;
      end
      S_DATA: begin
        if (hit15 && (bit_cnt == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (hit9) begin
          state_nxt = S_IDLE;
          if (stop_ok) begin
            done_nxt  = 1'b1;
            load_byte = 1'b1;
          end else begin
            ferr_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q   <= 3'd4;
      div_cnt  <= '0;
      tick_idx <= 4'd0;
    end else if ((state == S_IDLE) && rx_fall) begin
      baud_q   <= bus.set_baud;
      div_cnt  <= '0;
      tick_idx <= 4'd0;
    end else if (state != S_IDLE) begin
      if (tick) begin
        div_cnt  <= '0;
        tick_idx <= idx_nxt;
      end else begin
        div_cnt  <= div_cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp    <= 2'b11;
      shreg   <= 8'h00;
      bit_cnt <= 3'd0;
      stop_ok <= 1'b0;
    end else begin
      if (hit6) samp[0] <= rx_s2;
      if (hit7) samp[1] <= rx_s2;
      if ((state == S_DATA) && hit8) shreg <= {vote, shreg[7:1]};
      if ((state == S_STOP) && hit8) stop_ok <= vote;
      if (state == S_START) begin
        bit_cnt <= 3'd0;
      end else if ((state == S_DATA) && hit15) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_byte_q  <= 8'h00;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      uart_state_q <= 1'b0;
    end else begin
      if (load_byte) data_byte_q <= shreg;
      rx_done_q    <= done_nxt;
      frame_err_q  <= ferr_nxt;
      uart_state_q <= (state_nxt != S_IDLE);
    end
  end

  assign bus.data_byte  = data_byte_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.uart_state = uart_state_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed scenarios plus randomized frames,
// checked against a frame-level model of expected bytes, framing errors and last good byte.
module tb_uart_byte_rx;

  // Reduced clock keeps the slow-baud frames short; dividers follow CLK_FREQ/(BAUD*16).
  localparam int unsigned CLK_FREQ = 16_000_000;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  uart_byte_rx_if bus ();

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // Observed events.
  logic [7:0] got_q[$];
  int         got_t[$];
  int         ferr_seen = 0;
  logic       prev_pulse = 1'b0;
  logic       saw_busy = 1'b0;

  // Reference model.
  logic [7:0] exp_q[$];
  int         exp_ferr = 0;
  logic [7:0] exp_last = 8'h00;
  int         t_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int n_of(input int sel);
    int baud;
    case (sel)
      0:       baud = 9600;
      1:       baud = 19200;
      2:       baud = 38400;
      3:       baud = 57600;
      default: baud = 115200;
    endcase
    return int'(CLK_FREQ) / (baud * 16);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_pulse = 1'b0;
    end else begin
      if (bus.rx_done || bus.frame_err) begin
        check("strobe_exclusive", 32'(bus.rx_done & bus.frame_err), 32'd0);
        check("strobe_one_cycle", 32'(prev_pulse), 32'd0);
      end
      if (bus.rx_done) begin
        got_q.push_back(bus.data_byte);
        got_t.push_back(cyc);
      end
      if (bus.frame_err) ferr_seen++;
      if (bus.uart_state) saw_busy = 1'b1;
      prev_pulse = bus.rx_done | bus.frame_err;
    end
  end

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Sends one 8N1 frame; entered and left on a negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_clk,
                            input bit glitch, input bit scramble);
    logic [2:0] saved;
    saved  = bus.set_baud;
    t_fall = cyc;
    hold(1'b0, bit_clk);
    if (scramble) bus.set_baud = 3'($urandom_range(0, 7));
    for (int i = 0; i < 8; i++) begin
      if (glitch) begin
        hold(b[i], bit_clk / 2);
        hold(~b[i], 1);
        hold(b[i], bit_clk - bit_clk / 2 - 1);
      end else begin
        hold(b[i], bit_clk);
      end
    end
    hold(stop_bit, bit_clk);
    bus.set_baud = saved;
    if (stop_bit) begin
      exp_q.push_back(b);
      exp_last = b;
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic verify(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, "_frame_err"}, 32'(ferr_seen), 32'(exp_ferr));
    check({tag, "_data_byte"}, 32'(bus.data_byte), 32'(exp_last));
    check({tag, "_uart_state"}, 32'(bus.uart_state), 32'd0);
    got_q.delete();
    got_t.delete();
    exp_q.delete();
    ferr_seen = 0;
    exp_ferr  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_byte"}, 32'(bus.data_byte), 32'h00);
    check({tag, "_rx_done"}, 32'(bus.rx_done), 32'd0);
    check({tag, "_frame_err"}, 32'(bus.frame_err), 32'd0);
    check({tag, "_uart_state"}, 32'(bus.uart_state), 32'd0);
  endtask

  initial begin
    int n4, n0, bit4, bit0, lat, lat_exp;
    logic [7:0] b;
    logic       sb;
    int         sel, gap;

    n4   = n_of(4);
    n0   = n_of(0);
    bit4 = 16 * n4;
    bit0 = 16 * n0;

    bus.rx       = 1'b1;
    bus.set_baud = 3'd4;
    rst          = 1'b0;
    #1 rst       = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    hold(1'b1, 20);

    // 1: single frame, plus start-edge to rx_done latency.
    send_frame(8'h55, 1'b1, bit4, 1'b0, 1'b0);
    hold(1'b1, 2 * bit4);
    lat_exp = 153 * n4 + 3;
    lat     = (got_t.size() > 0) ? got_t[0] - t_fall : -1;
    n_checks++;
    assert (lat >= lat_exp - 1 && lat <= lat_exp + 1) else begin
      n_errors++;
      $error("FAIL t1_latency: observed %0d expected %0d (+-1)", lat, lat_exp);
    end
    verify("t1");

    // 2: back-to-back frames, no idle bits.
    send_frame(8'hA5, 1'b1, bit4, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, bit4, 1'b0, 1'b0);
    hold(1'b1, 2 * bit4);
    verify("t2");

    // 3: short low pulse is a false start.
    saw_busy = 1'b0;
    hold(1'b0, 4 * n4);
    hold(1'b1, 2 * bit4);
    check("t3_busy_seen", 32'(saw_busy), 32'd1);
    verify("t3");

    // 4: framing error keeps old byte, then a good frame.
    send_frame(8'hF0, 1'b0, bit4, 1'b0, 1'b0);
    hold(1'b1, 2 * bit4);
    verify("t4a");
    send_frame(8'h0F, 1'b1, bit4, 1'b0, 1'b0);
    hold(1'b1, 2 * bit4);
    verify("t4b");

    // 5: slowest rate with mid-bit glitches, then a 2% fast sender.
    bus.set_baud = 3'd0;
    hold(1'b1, 20);
    send_frame(8'h96, 1'b1, bit0, 1'b1, 1'b0);
    hold(1'b1, bit0);
    send_frame(8'h81, 1'b1, (bit0 * 100) / 102, 1'b0, 1'b0);
    hold(1'b1, bit0);
    verify("t5");
    bus.set_baud = 3'd4;

    // 6: reset during bit 4 aborts the frame (bit 4 of 0x5A is 1).
    b = 8'h5A;
    hold(1'b0, bit4);
    for (int i = 0; i < 4; i++) hold(b[i], bit4);
    hold(b[4], bit4 / 2);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_last = 8'h00;
    check_reset_outputs("t6_reset");
    hold(1'b1, 12 * bit4);
    send_frame(8'h81, 1'b1, bit4, 1'b0, 1'b0);
    hold(1'b1, 2 * bit4);
    verify("t6");

    // Random frames at mixed rates, set_baud disturbed mid-frame.
    for (int k = 0; k < 5; k++) begin
      sel          = $urandom_range(3, 4);
      bus.set_baud = 3'(sel);
      hold(1'b1, 4);
      b   = 8'($urandom);
      sb  = ($urandom_range(0, 3) != 0);
      send_frame(b, sb, 16 * n_of(sel), 1'b0, 1'b1);
      gap = sb ? $urandom_range(0, 2) : 2;
      hold(1'b1, gap * 16 * n_of(sel) + 8);
      verify("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
